// File: rtl/packet_sort_pkg.sv
// Shared state and direction definitions for packet_sort_oet.
// Optional build macro used by this block: PACKET_SORT_SIGNED_EN (see packet_sort_cas).
package packet_sort_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        UNLOAD
    } state_t;

    localparam logic ORDER_ASC  = 1'b0;
    localparam logic ORDER_DESC = 1'b1;

endpackage

// File: rtl/packet_sort_cas.sv
// Combinational compare-swap element for the odd-even transposition network.
// PACKET_SORT_SIGNED_EN selects two's-complement comparison; unsigned otherwise.
module packet_sort_cas
    import packet_sort_pkg::*;
#(
    parameter int unsigned DWIDTH = 8
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic              order,
    input  logic              enable,
    output logic [DWIDTH-1:0] lo,
    output logic [DWIDTH-1:0] hi
);

    logic a_gt_b;
    logic b_gt_a;
    logic swap;

    always_comb begin
`ifdef PACKET_SORT_SIGNED_EN
        a_gt_b = $signed(a) > $signed(b);
        b_gt_a = $signed(b) > $signed(a);
`else
        a_gt_b = a > b;
        b_gt_a = b > a;
`endif
        swap = enable & ((order == ORDER_DESC) ? b_gt_a : a_gt_b);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/packet_sort_oet.sv
// Avalon-ST packet sorter: buffer one packet, odd-even transposition sort, stream out.
// Build option PACKET_SORT_SIGNED_EN makes the compare-swap signed.
module packet_sort_oet
    import packet_sort_pkg::*;
#(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned MAX_PKT_LEN = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    input  logic              snk_order_i,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              src_overflow_o
);

    localparam int unsigned   LW      = $clog2(MAX_PKT_LEN + 1);
    localparam int unsigned   NP      = MAX_PKT_LEN - 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_PKT_LEN);

    state_t            state;
    logic [LW-1:0]     length;
    logic [LW-1:0]     pass;
    logic [LW-1:0]     rd_idx;
    logic [LW-1:0]     rd_sel;
    logic [LW-1:0]     wr_idx;
    logic [LW-1:0]     last_idx;
    logic              order;
    logic              overflow;
    logic              accept;
    logic              wr_en;
    logic [DWIDTH-1:0] rd_word;
    logic [DWIDTH-1:0] slot   [MAX_PKT_LEN];
    logic [DWIDTH-1:0] sorted [MAX_PKT_LEN];
    logic [DWIDTH-1:0] cas_lo [NP];
    logic [DWIDTH-1:0] cas_hi [NP];
    logic [NP-1:0]     cas_en;

    assign accept   = snk_valid_i & snk_ready_o;
    assign last_idx = length - LW'(1);

    // Pair g compares slots g and g+1; even passes use even g, odd passes odd g.
    for (genvar g = 0; g < NP; g++) begin : g_cas
        assign cas_en[g] = (state == SORT) && (pass[0] == 1'(g % 2)) && (LW'(g + 1) < length);
        packet_sort_cas #(
            .DWIDTH(DWIDTH)
        ) u_cas (
            .a     (slot[g]),
            .b     (slot[g+1]),
            .order (order),
            .enable(cas_en[g]),
            .lo    (cas_lo[g]),
            .hi    (cas_hi[g])
        );
    end

    // At most one enabled pair touches a slot in any pass.
    for (genvar j = 0; j < MAX_PKT_LEN; j++) begin : g_slot
        if (j == 0) begin : g_first
            assign sorted[j] = cas_en[0] ? cas_lo[0] : slot[0];
        end else if (j == MAX_PKT_LEN - 1) begin : g_last
            assign sorted[j] = cas_en[j-1] ? cas_hi[j-1] : slot[j];
        end else begin : g_mid
            assign sorted[j] = cas_en[j] ? cas_lo[j] : (cas_en[j-1] ? cas_hi[j-1] : slot[j]);
        end
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        if (accept) begin
            if (snk_startofpacket_i) begin
                wr_en = 1'b1;
            end else if (state == LOAD && length < LEN_MAX) begin
                wr_en  = 1'b1;
                wr_idx = length;
            end
        end
    end

    // Next word to present: current slot before the first load, else the following one.
    assign rd_sel = src_valid_o ? rd_idx + LW'(1) : rd_idx;

    always_comb begin
        rd_word = '0;
        for (int unsigned j = 0; j < MAX_PKT_LEN; j++) begin
            if (rd_sel == LW'(j)) rd_word = slot[j];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned j = 0; j < MAX_PKT_LEN; j++) begin
            if (state == SORT) begin
                slot[j] <= sorted[j];
            end else if (wr_en && wr_idx == LW'(j)) begin
                slot[j] <= snk_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state               <= IDLE;
            length              <= '0;
            pass                <= '0;
            rd_idx              <= '0;
            order               <= ORDER_ASC;
            overflow            <= 1'b0;
            snk_ready_o         <= 1'b0;
            src_data_o          <= '0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
            src_valid_o         <= 1'b0;
            src_overflow_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    snk_ready_o <= 1'b1;
                    if (accept && snk_startofpacket_i) begin
                        length   <= LW'(1);
                        order    <= snk_order_i;
                        overflow <= 1'b0;
                        pass     <= '0;
                        if (snk_endofpacket_i) begin
                            state       <= SORT;
                            snk_ready_o <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (snk_startofpacket_i) begin
                            length   <= LW'(1);
                            order    <= snk_order_i;
                            overflow <= 1'b0;
                        end else if (length < LEN_MAX) begin
                            length <= length + LW'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                        pass <= '0;
                        if (snk_endofpacket_i) begin
                            state       <= SORT;
                            snk_ready_o <= 1'b0;
                        end
                    end
                end
                SORT: begin
                    if (pass == last_idx) begin
                        state  <= UNLOAD;
                        rd_idx <= '0;
                    end else begin
                        pass <= pass + LW'(1);
                    end
                end
                UNLOAD: begin
                    if (src_valid_o && src_ready_i && src_endofpacket_o) begin
                        state               <= IDLE;
                        snk_ready_o         <= 1'b1;
                        src_valid_o         <= 1'b0;
                        src_data_o          <= '0;
                        src_startofpacket_o <= 1'b0;
                        src_endofpacket_o   <= 1'b0;
                        src_overflow_o      <= 1'b0;
                    end else if (!src_valid_o || src_ready_i) begin
                        rd_idx              <= rd_sel;
                        src_valid_o         <= 1'b1;
                        src_data_o          <= rd_word;
                        src_startofpacket_o <= (rd_sel == '0);
                        src_endofpacket_o   <= (rd_sel == last_idx);
                        src_overflow_o      <= overflow && (rd_sel == last_idx);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_sort_oet.sv
// Self-checking bench for packet_sort_oet with a queue-based sorting reference.
// Expectations follow PACKET_SORT_SIGNED_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_packet_sort_oet;
    import packet_sort_pkg::*;

    typedef logic [7:0] q8_t [$];

    logic       clk;
    logic       arst_n_i;
    logic [7:0] snk_data_i;
    logic       snk_startofpacket_i;
    logic       snk_endofpacket_i;
    logic       snk_valid_i;
    logic       snk_ready_o;
    logic       snk_order_i;
    logic [7:0] src_data_o;
    logic       src_startofpacket_o;
    logic       src_endofpacket_o;
    logic       src_valid_o;
    logic       src_ready_i;
    logic       src_overflow_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int eop_cyc = 0;
    int first_lat;
    bit tx_timeout;
    bit rx_timeout;
    bit snk_rdy_seen;
    bit valid_after;
    logic [7:0] rx_data [$];
    bit         rx_sop  [$];
    bit         rx_eop  [$];
    bit         rx_ovf  [$];

    packet_sort_oet #(
        .DWIDTH     (8),
        .MAX_PKT_LEN(16)
    ) dut (
        .clk_i              (clk),
        .arst_n_i           (arst_n_i),
        .snk_data_i         (snk_data_i),
        .snk_startofpacket_i(snk_startofpacket_i),
        .snk_endofpacket_i  (snk_endofpacket_i),
        .snk_valid_i        (snk_valid_i),
        .snk_ready_o        (snk_ready_o),
        .snk_order_i        (snk_order_i),
        .src_data_o         (src_data_o),
        .src_startofpacket_o(src_startofpacket_o),
        .src_endofpacket_o  (src_endofpacket_o),
        .src_valid_o        (src_valid_o),
        .src_ready_i        (src_ready_i),
        .src_overflow_o     (src_overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int key(input logic [7:0] x);
`ifdef PACKET_SORT_SIGNED_EN
        return int'($signed(x));
`else
        return int'(x);
`endif
    endfunction

    // Plain insertion sort on the packet's words.
    function automatic q8_t model_sort(input q8_t in, input bit desc);
        q8_t        q;
        logic [7:0] t;
        q = in;
        for (int i = 1; i < q.size(); i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (key(q[j-1]) < key(q[j])) : (key(q[j-1]) > key(q[j]))) begin
                    t = q[j]; q[j] = q[j-1]; q[j-1] = t;
                end
            end
        end
        return q;
    endfunction

    task automatic send_word(input logic [7:0] d, input bit sop, input bit eop,
                             input bit ord, input int gap_pct);
        int  guard;
        bit  acc;
        guard = 0;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct && guard < 4) begin
            snk_valid_i = 1'b0;
            @(posedge clk); #1;
            guard++;
        end
        snk_data_i          = d;
        snk_startofpacket_i = sop;
        snk_endofpacket_i   = eop;
        snk_order_i         = ord;
        snk_valid_i         = 1'b1;
        guard = 0;
        forever begin
            acc = snk_ready_o;
            @(posedge clk); #1;
            if (acc) break;
            guard++;
            if (guard > 100) begin tx_timeout = 1'b1; break; end
        end
        snk_valid_i = 1'b0;
        if (eop) eop_cyc = cyc;
    endtask

    task automatic send_packet(input q8_t w, input bit ord, input int gap_pct);
        for (int i = 0; i < w.size(); i++)
            send_word(w[i], i == 0, i == w.size() - 1, ord, gap_pct);
    endtask

    task automatic recv_packet(input bit rand_ready);
        bit r, take, last, done;
        rx_data.delete(); rx_sop.delete(); rx_eop.delete(); rx_ovf.delete();
        first_lat = -1; rx_timeout = 1'b0; snk_rdy_seen = 1'b0; done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            r = rand_ready ? 1'($urandom_range(1)) : 1'b1;
            src_ready_i = r;
            if (snk_ready_o) snk_rdy_seen = 1'b1;
            if (src_valid_o && first_lat < 0) first_lat = cyc - eop_cyc;
            take = src_valid_o && r;
            last = src_endofpacket_o;
            if (take) begin
                rx_data.push_back(src_data_o); rx_sop.push_back(src_startofpacket_o);
                rx_eop.push_back(src_endofpacket_o); rx_ovf.push_back(src_overflow_o);
            end
            @(posedge clk); #1;
            if (take && last) begin done = 1'b1; break; end
        end
        if (!done) rx_timeout = 1'b1;
        valid_after = src_valid_o;
        src_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        arst_n_i = 1'b1;
        #1 arst_n_i = 1'b0;
        #2;
        n_tests++;
        if (snk_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_snk_ready: got %b expected 0", snk_ready_o);
        end
        n_tests++;
        if ({src_valid_o, src_startofpacket_o, src_endofpacket_o, src_overflow_o, src_data_o} !== 12'h000) begin
            n_fail++; $display("FAIL reset_src: got %h expected 000",
                               {src_valid_o, src_startofpacket_o, src_endofpacket_o, src_overflow_o, src_data_o});
        end
        @(negedge clk); arst_n_i = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (snk_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b expected 1", snk_ready_o);
        end
    endtask

    // Generic packet scenario; comparisons are inline below.
    task automatic test_packet(input string name, input q8_t w, input bit ord, input int gap_pct,
                               input bit rand_ready, input int keep, input bit exp_ovf);
        q8_t e, kept;
        int  n;
        for (int i = 0; i < keep && i < w.size(); i++) kept.push_back(w[i]);
        e = model_sort(kept, ord);
        n = e.size();
        tx_timeout = 1'b0;
        send_packet(w, ord, gap_pct);
        recv_packet(rand_ready);
        n_tests++;
        if ({tx_timeout, rx_timeout} !== 2'b00) begin
            n_fail++; $display("FAIL %s_timeout: got tx=%b rx=%b expected 0 0", name, tx_timeout, rx_timeout);
        end
        n_tests++;
        if (rx_data.size() !== n) begin
            n_fail++; $display("FAIL %s_count: got %0d expected %0d", name, rx_data.size(), n);
        end
        for (int i = 0; i < n && i < rx_data.size(); i++) begin
            n_tests++;
            if ({rx_data[i], rx_sop[i], rx_eop[i], rx_ovf[i]} !==
                {e[i], i == 0, i == n - 1, exp_ovf && (i == n - 1)}) begin
                n_fail++;
                $display("FAIL %s_word%0d: got data=%h sop=%b eop=%b ovf=%b expected data=%h sop=%b eop=%b ovf=%b",
                         name, i, rx_data[i], rx_sop[i], rx_eop[i], rx_ovf[i],
                         e[i], i == 0, i == n - 1, exp_ovf && (i == n - 1));
            end
        end
        n_tests++;
        if (first_lat !== n + 1) begin
            n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, first_lat, n + 1);
        end
        n_tests++;
        if (snk_rdy_seen !== 1'b0) begin
            n_fail++; $display("FAIL %s_snk_ready_busy: got 1 expected 0", name);
        end
        n_tests++;
        if (valid_after !== 1'b0) begin
            n_fail++; $display("FAIL %s_valid_after_eop: got %b expected 0", name, valid_after);
        end
    endtask

    task automatic test_two_word();
        test_packet("two_word", {8'h80, 8'h01}, ORDER_ASC, 0, 1'b0, 16, 1'b0);
    endtask

    task automatic test_random_desc();
        q8_t w;
        for (int i = 0; i < 10; i++) w.push_back(8'($urandom));
        test_packet("rand_desc", w, ORDER_DESC, 50, 1'b1, 16, 1'b0);
    endtask

    task automatic test_single_word();
        test_packet("single", {8'h5A}, ORDER_ASC, 0, 1'b0, 16, 1'b0);
    endtask

    task automatic test_overflow();
        q8_t w;
        for (int i = 0; i < 18; i++) w.push_back(8'($urandom));
        test_packet("overflow", w, ORDER_ASC, 0, 1'b1, 16, 1'b1);
    endtask

    // Stray non-SOP word in IDLE, then an aborted ascending packet, then the real one.
    task automatic test_restart();
        q8_t w;
        send_word(8'hEE, 1'b0, 1'b0, ORDER_ASC, 0);
        send_word(8'h11, 1'b1, 1'b0, ORDER_ASC, 0);
        send_word(8'h22, 1'b0, 1'b0, ORDER_ASC, 0);
        send_word(8'h33, 1'b0, 1'b0, ORDER_ASC, 0);
        for (int i = 0; i < 5; i++) w.push_back(8'($urandom));
        test_packet("restart", w, ORDER_DESC, 0, 1'b0, 16, 1'b0);
    endtask

    task automatic test_backpressure();
        q8_t w, e;
        int  guard;
        bit  stalled;
        w = {8'h40, 8'h05, 8'hC3, 8'h05, 8'h99, 8'h10};
        e = model_sort(w, ORDER_ASC);
        send_packet(w, ORDER_ASC, 0);
        rx_data.delete();
        src_ready_i = 1'b1;
        guard = 0; stalled = 1'b0;
        while (rx_data.size() < 6 && guard < 200) begin
            if (rx_data.size() == 2 && !stalled) begin
                stalled = 1'b1;
                src_ready_i = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    n_tests++;
                    if ({src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o, src_overflow_o} !==
                        {1'b1, e[2], 3'b000}) begin
                        n_fail++;
                        $display("FAIL stall_hold%0d: got valid=%b data=%h sop=%b eop=%b ovf=%b expected valid=1 data=%h sop=0 eop=0 ovf=0",
                                 k, src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o, src_overflow_o, e[2]);
                    end
                    @(posedge clk); #1;
                end
                src_ready_i = 1'b1;
            end
            if (src_valid_o) rx_data.push_back(src_data_o);
            @(posedge clk); #1;
            guard++;
        end
        n_tests++;
        if (rx_data.size() !== 6) begin
            n_fail++; $display("FAIL stall_count: got %0d expected 6", rx_data.size());
        end
        for (int i = 0; i < 6 && i < rx_data.size(); i++) begin
            n_tests++;
            if (rx_data[i] !== e[i]) begin
                n_fail++; $display("FAIL stall_word%0d: got %h expected %h", i, rx_data[i], e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        q8_t w;
        int  guard;
        for (int i = 0; i < 8; i++) w.push_back(8'($urandom));
        send_packet(w, ORDER_ASC, 0);
        repeat (3) @(posedge clk);
        #2 arst_n_i = 1'b0;
        #1;
        n_tests++;
        if ({snk_ready_o, src_valid_o, src_startofpacket_o, src_endofpacket_o, src_overflow_o, src_data_o} !== 13'h0) begin
            n_fail++; $display("FAIL reset_in_sort: got %h expected 0000",
                {snk_ready_o, src_valid_o, src_startofpacket_o, src_endofpacket_o, src_overflow_o, src_data_o});
        end
        @(negedge clk); arst_n_i = 1'b1;
        @(posedge clk); #1;
        // Second packet is caught while presenting its first word, then reset.
        w.delete();
        for (int i = 0; i < 5; i++) w.push_back(8'h80 | 8'($urandom));
        send_packet(w, ORDER_ASC, 0);
        src_ready_i = 1'b0;
        guard = 0;
        while (!src_valid_o && guard < 50) begin @(posedge clk); #1; guard++; end
        n_tests++;
        if (src_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_unload_reach: got valid=%b expected 1", src_valid_o);
        end
        #2 arst_n_i = 1'b0;
        #1;
        n_tests++;
        if ({src_valid_o, src_startofpacket_o, src_endofpacket_o, src_overflow_o, src_data_o} !== 12'h000) begin
            n_fail++; $display("FAIL reset_in_unload: got %h expected 000",
                {src_valid_o, src_startofpacket_o, src_endofpacket_o, src_overflow_o, src_data_o});
        end
        src_ready_i = 1'b1;
        @(negedge clk); arst_n_i = 1'b1;
        @(posedge clk); #1;
        w.delete();
        for (int i = 0; i < 7; i++) w.push_back(8'($urandom));
        test_packet("after_reset", w, ORDER_DESC, 0, 1'b0, 16, 1'b0);
    endtask

    task automatic test_signed();
        q8_t e;
        logic [7:0] w0;
`ifdef PACKET_SORT_SIGNED_EN
        e = {8'h80, 8'h00, 8'h7F};
`else
        e = {8'h00, 8'h7F, 8'h80};
`endif
        send_packet({8'h7F, 8'h80, 8'h00}, ORDER_ASC, 0);
        recv_packet(1'b0);
        n_tests++;
        if (rx_data.size() !== 3) begin
            n_fail++; $display("FAIL sign_count: got %0d expected 3", rx_data.size());
        end
        for (int i = 0; i < 3 && i < rx_data.size(); i++) begin
            w0 = e[i];
            n_tests++;
            if (rx_data[i] !== w0) begin
                n_fail++; $display("FAIL sign_word%0d: got %h expected %h", i, rx_data[i], w0);
            end
        end
    endtask

    initial begin
        snk_data_i = '0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
        snk_valid_i = 1'b0; snk_order_i = 1'b0; src_ready_i = 1'b1; arst_n_i = 1'b1;
        test_reset();
        test_two_word();
        test_random_desc();
        test_single_word();
        test_overflow();
        test_restart();
        test_backpressure();
        test_reset_mid();
        test_signed();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks failed so far", n_fail, n_tests);
        $fatal(1);
    end

endmodule
